// File: rtl/bit_field_ctrl.sv
// bit_field_ctrl: read-modify-write sequencer for single-bit and bit-field
// operations on a 16-bit register file. Accepts one command, reads the target
// register, rewrites bits lo..hi one position per cycle, writes back, and
// pulses done (with err for rejected commands).
module bit_field_ctrl #(
  parameter int unsigned RF_AW = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [RF_AW-1:0] cmd_reg,
  input  logic [3:0]       cmd_lo,
  input  logic [3:0]       cmd_hi,
  input  logic [15:0]      cmd_data,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [15:0]      rf_rdata,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [15:0]      rf_wdata,
  output logic             done,
  output logic             err,
  output logic [15:0]      result
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_MODIFY, S_WRITE, S_DONE, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    OP_SET    = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_TOGGLE = 3'd2,
    OP_INSERT = 3'd3,
    OP_TEST   = 3'd4
  } op_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [RF_AW-1:0] reg_q, reg_d;
  logic [3:0]       lo_q, lo_d;
  logic [3:0]       hi_q, hi_d;
  logic [15:0]      data_q, data_d;
  logic [15:0]      work_q, work_d;
  logic [15:0]      field_q, field_d;
  logic [3:0]       k_q, k_d;
  logic [3:0]       idx;

  logic             cmd_ready_q;
  logic [RF_AW-1:0] rf_raddr_q, rf_raddr_d;
  logic             rf_we_q;
  logic [RF_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [15:0]      rf_wdata_q, rf_wdata_d;
  logic             done_q;
  logic             err_q;
  logic [15:0]      result_q, result_d;

  // Next-state, datapath and next-output logic. Outputs are registered from
  // the next state so every output changes only on a clock edge.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    reg_d      = reg_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    data_d     = data_q;
    work_d     = work_q;
    field_d    = field_q;
    k_d        = k_q;
    idx        = k_q - lo_q;
    rf_raddr_d = rf_raddr_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    result_d   = result_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d   = cmd_op;
          reg_d  = cmd_reg;
          lo_d   = cmd_lo;
          hi_d   = cmd_hi;
          data_d = cmd_data;
          if ((cmd_op > 3'd4) || (cmd_hi < cmd_lo)) begin
            state_d  = S_ERR;
            result_d = '0;
          end else begin
            state_d    = S_READ;
            rf_raddr_d = cmd_reg;
          end
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        work_d  = rf_rdata;
        field_d = '0;
        k_d     = lo_q;
        state_d = S_MODIFY;
      end
      S_MODIFY: begin
        case (op_q)
          OP_SET:    work_d[k_q] = 1'b1;
          OP_CLEAR:  work_d[k_q] = 1'b0;
          OP_TOGGLE: work_d[k_q] = ~work_q[k_q];
          OP_INSERT: work_d[k_q] = data_q[idx];
          default:   field_d[idx] = work_q[k_q];
        endcase
        // Loop ends by comparing against hi before incrementing, so hi=15
        // never needs the pointer to reach 16.
        if (k_q == hi_q) begin
          if (op_q == OP_TEST) begin
            state_d  = S_DONE;
            result_d = field_d;
          end else begin
            state_d    = S_WRITE;
            rf_waddr_d = reg_q;
            rf_wdata_d = work_d;
          end
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_WRITE: begin
        state_d  = S_DONE;
        result_d = work_q;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured command, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      reg_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      data_q      <= '0;
      work_q      <= '0;
      field_q     <= '0;
      k_q         <= '0;
      cmd_ready_q <= 1'b0;
      rf_raddr_q  <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      data_q      <= data_d;
      work_q      <= work_d;
      field_q     <= field_d;
      k_q         <= k_d;
      cmd_ready_q <= (state_d == S_IDLE);
      rf_raddr_q  <= rf_raddr_d;
      rf_we_q     <= (state_d == S_WRITE);
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      done_q      <= (state_d == S_DONE) || (state_d == S_ERR);
      err_q       <= (state_d == S_ERR);
      result_q    <= result_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rf_raddr  = rf_raddr_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;

endmodule

// File: tb/tb_bit_field_ctrl.sv
// Directed testbench for bit_field_ctrl with a small register-file model.
module tb_bit_field_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_reg;
  logic [3:0]  cmd_lo;
  logic [3:0]  cmd_hi;
  logic [15:0] cmd_data;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        done;
  logic        err;
  logic [15:0] result;

  bit_field_ctrl #(.RF_AW(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_reg   (cmd_reg),
    .cmd_lo    (cmd_lo),
    .cmd_hi    (cmd_hi),
    .cmd_data  (cmd_data),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Register-file model: synchronous read, write on rf_we, bench preload port.
  logic [15:0] rf [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  always @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  // Accept counter sampled mid-cycle, away from the active edge.
  int acc_cnt = 0;
  always @(negedge clk) if (reset_n && cmd_valid && cmd_ready) acc_cnt++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  int          we_cyc, we_cnt, done_cyc;
  logic [2:0]  we_addr;
  logic [15:0] we_data, res_seen;
  logic        err_seen;

  // Issue one command and record, per cycle after the accepting edge, the
  // first write and the done pulse. Optionally changes cmd_* while holding
  // cmd_valid, or pulls reset at a given cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rg,
                         input logic [3:0] lo, input logic [3:0] hi,
                         input logic [15:0] data, input bit mutate,
                         input int abort_at);
    int b;
    we_cyc = 0; we_cnt = 0; done_cyc = 0;
    we_addr = '0; we_data = '0; res_seen = '0; err_seen = 1'b0;
    cmd_op = op; cmd_reg = rg; cmd_lo = lo; cmd_hi = hi; cmd_data = data;
    cmd_valid = 1'b1;
    b = 0;
    while (!cmd_ready && b < 20) begin
      @(posedge clk); #1;
      b++;
    end
    if (!cmd_ready) begin
      chk("accept_wait", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (mutate) begin
      cmd_op = 3'd0; cmd_reg = 3'd4; cmd_lo = 4'd8; cmd_hi = 4'd15; cmd_data = '1;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int c = 1; c <= 40; c++) begin
      if (rf_we) begin
        we_cnt++;
        if (we_cyc == 0) begin
          we_cyc = c; we_addr = rf_waddr; we_data = rf_wdata;
        end
      end
      if (done) begin
        done_cyc = c; err_seen = err; res_seen = result;
        break;
      end
      if (c == abort_at) begin
        reset_n = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  logic [2:0] raddr_before;
  int         acc0;

  initial begin
    reset_n = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0;
    cmd_lo = '0; cmd_hi = '0; cmd_data = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  {31'd0, cmd_ready}, 32'd0);
    chk("rst_done",   {31'd0, done},      32'd0);
    chk("rst_err",    {31'd0, err},       32'd0);
    chk("rst_we",     {31'd0, rf_we},     32'd0);
    chk("rst_wdata",  {16'd0, rf_wdata},  32'd0);
    chk("rst_result", {16'd0, result},    32'd0);
    reset_n = 1'b1;
    chk("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", {31'd0, cmd_ready}, 32'd1);

    // SET reg2 bits 4..7 over 0x0000
    preload(3'd2, 16'h0000);
    run_cmd(3'd0, 3'd2, 4'd4, 4'd7, 16'h0000, 1'b0, 0);
    chk("set_we_cyc",   we_cyc,   7);
    chk("set_we_cnt",   we_cnt,   1);
    chk("set_waddr",    we_addr,  2);
    chk("set_wdata",    we_data,  16'h00F0);
    chk("set_done_cyc", done_cyc, 8);
    chk("set_err",      err_seen, 0);
    chk("set_result",   res_seen, 16'h00F0);

    // INSERT full width into reg5 over 0xFFFF
    preload(3'd5, 16'hFFFF);
    run_cmd(3'd3, 3'd5, 4'd0, 4'd15, 16'hA5C3, 1'b0, 0);
    chk("ins_we_cyc",   we_cyc,   19);
    chk("ins_we_cnt",   we_cnt,   1);
    chk("ins_wdata",    we_data,  16'hA5C3);
    chk("ins_done_cyc", done_cyc, 20);
    chk("ins_result",   res_seen, 16'hA5C3);
    chk("ins_rf5",      rf[5],    16'hA5C3);

    // TEST reg1 bits 4..11 of 0x1234
    preload(3'd1, 16'h1234);
    run_cmd(3'd4, 3'd1, 4'd4, 4'd11, 16'h0000, 1'b0, 0);
    chk("test_done_cyc", done_cyc, 11);
    chk("test_we_cnt",   we_cnt,   0);
    chk("test_err",      err_seen, 0);
    chk("test_result",   res_seen, 16'h0023);

    // TOGGLE reg1 bit 15 of 0x8001
    preload(3'd1, 16'h8001);
    run_cmd(3'd2, 3'd1, 4'd15, 4'd15, 16'h0000, 1'b0, 0);
    chk("tog_we_cyc",   we_cyc,   4);
    chk("tog_wdata",    we_data,  16'h0001);
    chk("tog_done_cyc", done_cyc, 5);
    chk("tog_result",   res_seen, 16'h0001);

    // Illegal op 111
    raddr_before = rf_raddr;
    run_cmd(3'd7, 3'd2, 4'd0, 4'd3, 16'h0000, 1'b0, 0);
    chk("ill_done_cyc", done_cyc, 1);
    chk("ill_err",      err_seen, 1);
    chk("ill_result",   res_seen, 0);
    chk("ill_we_cnt",   we_cnt,   0);
    chk("ill_raddr",    rf_raddr, raddr_before);
    @(posedge clk); #1;
    chk("ill_ready_back", {31'd0, cmd_ready}, 32'd1);

    // hi < lo
    run_cmd(3'd0, 3'd6, 4'd9, 4'd3, 16'h0000, 1'b0, 0);
    chk("rng_done_cyc", done_cyc, 1);
    chk("rng_err",      err_seen, 1);
    chk("rng_result",   res_seen, 0);
    chk("rng_we_cnt",   we_cnt,   0);
    chk("rng_raddr",    rf_raddr, raddr_before);
    @(posedge clk); #1;
    chk("rng_ready_back", {31'd0, cmd_ready}, 32'd1);

    // CLEAR reg3 bits 0..7 with cmd_valid held and cmd_* changed mid-flight
    preload(3'd3, 16'hABCD);
    preload(3'd4, 16'h0000);
    acc0 = acc_cnt;
    run_cmd(3'd1, 3'd3, 4'd0, 4'd7, 16'h0000, 1'b1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_accepts",  acc_cnt - acc0, 1);
    chk("hold_waddr",    we_addr,  3);
    chk("hold_wdata",    we_data,  16'hAB00);
    chk("hold_we_cnt",   we_cnt,   1);
    chk("hold_done_cyc", done_cyc, 12);
    chk("hold_rf4",      rf[4],    16'h0000);

    // Reset during MODIFY of SET reg6 bits 0..3
    preload(3'd6, 16'h1230);
    run_cmd(3'd0, 3'd6, 4'd0, 4'd3, 16'h0000, 1'b0, 4);
    #1;
    chk("abort_we",     {31'd0, rf_we},     32'd0);
    chk("abort_done",   {31'd0, done},      32'd0);
    chk("abort_ready",  {31'd0, cmd_ready}, 32'd0);
    chk("abort_wdata",  {16'd0, rf_wdata},  32'd0);
    chk("abort_result", {16'd0, result},    32'd0);
    chk("abort_we_cnt", we_cnt,   0);
    chk("abort_no_done", done_cyc, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_rf6", rf[6], 16'h1230);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Command after release completes normally
    run_cmd(3'd0, 3'd6, 4'd0, 4'd3, 16'h0000, 1'b0, 0);
    chk("post_we_cyc",   we_cyc,   7);
    chk("post_wdata",    we_data,  16'h123F);
    chk("post_done_cyc", done_cyc, 8);
    chk("post_result",   res_seen, 16'h123F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
